// File: rtl/dmem_access_unit_pkg.sv
// rtl/dmem_access_unit_pkg.sv - shared types for the data-memory access unit
package dmem_access_unit_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_LANES  = DMEM_DATA_W / 8;

    typedef enum logic [2:0] {
        LF_LB  = 3'd0,
        LF_LH  = 3'd1,
        LF_LW  = 3'd2,
        LF_LBU = 3'd4,
        LF_LHU = 3'd5
    } load_funct3_t;

    typedef enum logic [2:0] {
        SF_SB = 3'd0,
        SF_SH = 3'd1,
        SF_SW = 3'd2
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_access_unit_align.sv
// rtl/dmem_access_unit_align.sv - byte-lane steering, load extension and alignment check
module dmem_align
    import dmem_access_unit_pkg::*;
(
    input  logic [2:0]             i_funct3,
    input  logic                   i_is_write,
    input  logic [1:0]             i_offset,
    input  logic [DMEM_DATA_W-1:0] i_wdata,
    input  logic [DMEM_DATA_W-1:0] i_rdata,
    output logic [DMEM_LANES-1:0]  o_wmask,
    output logic [DMEM_DATA_W-1:0] o_wdata,
    output logic [DMEM_DATA_W-1:0] o_rdata,
    output logic                   o_err
);

    logic [DMEM_DATA_W-1:0] w_rshift;
    logic [4:0]             w_bit_off;

    assign w_bit_off = {i_offset, 3'b000};
    assign w_rshift  = i_rdata >> w_bit_off;

    always_comb begin
        o_wmask = '0;
        o_wdata = '0;
        o_rdata = '0;
        o_err   = 1'b0;
        if (i_is_write) begin
            case (i_funct3)
                SF_SB: begin
                    o_wmask = 4'b0001 << i_offset;
                    o_wdata = {24'b0, i_wdata[7:0]} << w_bit_off;
                end
                SF_SH: begin
                    o_err   = i_offset[0];
                    o_wmask = 4'b0011 << i_offset;
                    o_wdata = {16'b0, i_wdata[15:0]} << w_bit_off;
                end
                SF_SW: begin
                    o_err   = (i_offset != 2'b00);
                    o_wmask = 4'b1111;
                    o_wdata = i_wdata;
                end
                default: o_err = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                LF_LB:  o_rdata = {{24{w_rshift[7]}}, w_rshift[7:0]};
                LF_LBU: o_rdata = {24'b0, w_rshift[7:0]};
                LF_LH: begin
                    o_err   = i_offset[0];
                    o_rdata = {{16{w_rshift[15]}}, w_rshift[15:0]};
                end
                LF_LHU: begin
                    o_err   = i_offset[0];
                    o_rdata = {16'b0, w_rshift[15:0]};
                end
                LF_LW: begin
                    o_err   = (i_offset != 2'b00);
                    o_rdata = i_rdata;
                end
                default: o_err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - memory-stage load/store executor with pipeline stall
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_read,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_stall,
    output logic [ADDR_W-1:0] o_dmem_address,
    output logic              o_dmem_read,
    output logic              o_dmem_write,
    output logic [3:0]        o_dmem_wmask,
    output logic [DATA_W-1:0] o_dmem_wdata,
    input  logic [DATA_W-1:0] i_dmem_rdata,
    input  logic              i_dmem_resp
);

    dmem_state_t r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic        r_is_write;

    logic [2:0]        w_sel_funct3;
    logic [1:0]        w_sel_offset;
    logic              w_sel_write;
    logic [3:0]        w_wmask;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata_ext;
    logic              w_align_err;
    logic              w_accept;
    logic              w_req_err;

    // One aligner serves both phases: the incoming request while IDLE, the latched request afterwards.
    assign w_sel_funct3 = (r_state == IDLE) ? i_req_funct3   : r_funct3;
    assign w_sel_offset = (r_state == IDLE) ? i_req_addr[1:0] : r_offset;
    assign w_sel_write  = (r_state == IDLE) ? i_req_write    : r_is_write;

    dmem_align u_align (
        .i_funct3   (w_sel_funct3),
        .i_is_write (w_sel_write),
        .i_offset   (w_sel_offset),
        .i_wdata    (i_req_wdata),
        .i_rdata    (i_dmem_rdata),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata_ext),
        .o_err      (w_align_err)
    );

    assign w_accept  = (r_state == IDLE) && o_req_ready && i_req_valid
                       && (i_req_read || i_req_write);
    assign w_req_err = (i_req_read && i_req_write) || w_align_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_funct3       <= '0;
            r_offset       <= '0;
            r_is_write     <= 1'b0;
            o_req_ready    <= 1'b0;
            o_resp_valid   <= 1'b0;
            o_resp_rdata   <= '0;
            o_resp_err     <= 1'b0;
            o_stall        <= 1'b0;
            o_dmem_address <= '0;
            o_dmem_read    <= 1'b0;
            o_dmem_write   <= 1'b0;
            o_dmem_wmask   <= '0;
            o_dmem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_req_ready <= 1'b1;
                    if (w_accept) begin
                        o_req_ready <= 1'b0;
                        o_stall     <= 1'b1;
                        r_funct3    <= i_req_funct3;
                        r_offset    <= i_req_addr[1:0];
                        r_is_write  <= i_req_write;
                        if (w_req_err) begin
                            r_state      <= RESP;
                            o_resp_valid <= 1'b1;
                            o_resp_err   <= 1'b1;
                            o_resp_rdata <= '0;
                        end else begin
                            r_state        <= ACCESS;
                            o_dmem_address <= {i_req_addr[ADDR_W-1:2], 2'b00};
                            o_dmem_read    <= i_req_read;
                            o_dmem_write   <= i_req_write;
                            o_dmem_wmask   <= i_req_write ? w_wmask : 4'b0000;
                            o_dmem_wdata   <= i_req_write ? w_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (i_dmem_resp) begin
                        r_state        <= RESP;
                        o_dmem_address <= '0;
                        o_dmem_read    <= 1'b0;
                        o_dmem_write   <= 1'b0;
                        o_dmem_wmask   <= '0;
                        o_dmem_wdata   <= '0;
                        o_resp_valid   <= 1'b1;
                        o_resp_err     <= 1'b0;
                        o_resp_rdata   <= r_is_write ? '0 : w_rdata_ext;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    o_resp_valid <= 1'b0;
                    o_resp_rdata <= '0;
                    o_resp_err   <= 1'b0;
                    o_stall      <= 1'b0;
                    o_req_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    o_stall     <= 1'b0;
                    o_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized self-checking bench for dmem_access_unit
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_resp = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_read     (req_read),
        .i_req_write    (req_write),
        .i_req_funct3   (req_funct3),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err),
        .o_stall        (stall),
        .o_dmem_address (dmem_address),
        .o_dmem_read    (dmem_read),
        .o_dmem_write   (dmem_write),
        .o_dmem_wmask   (dmem_wmask),
        .o_dmem_wdata   (dmem_wdata),
        .i_dmem_rdata   (dmem_rdata),
        .i_dmem_resp    (dmem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_err(input bit rd, input bit wr, input int f3, input int off);
        if (rd && wr) return 1;
        if (wr) begin
            if (f3 >= 3) return 1;
            if (f3 == 1 && (off % 2) != 0) return 1;
            if (f3 == 2 && off != 0) return 1;
        end else begin
            if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
            if ((f3 == 1 || f3 == 5) && (off % 2) != 0) return 1;
            if (f3 == 2 && off != 0) return 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * off);
        case (f3)
            0: begin sh = sh % 256;   if (sh >= 128)   sh = sh + 32'hFFFFFF00; end
            4: sh = sh % 256;
            1: begin sh = sh % 65536; if (sh >= 32768) sh = sh + 32'hFFFF0000; end
            5: sh = sh % 65536;
            default: sh = word;
        endcase
        return sh;
    endfunction

    function automatic logic [3:0] model_mask(input int f3, input int off);
        if (f3 == 0) return 4'(1 << off);
        if (f3 == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input int f3, input int off, input logic [31:0] wd);
        if (f3 == 0) return (wd % 256) * (32'd1 << (8 * off));
        if (f3 == 1) return (wd % 65536) * (32'd1 << (8 * off));
        return wd;
    endfunction

    // One complete transaction: present request, act as memory after 'delay' ACCESS cycles, check response.
    task automatic do_req(input bit rd, input bit wr, input int f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int delay);
        int off;
        bit err;
        off = int'(addr % 4);
        err = model_err(rd, wr, f3, off);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_funct3 = 3'(f3); req_addr = addr; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        chk("stall_after_accept", 32'(stall), 32'd1);
        if (err) begin
            chk("err_resp_valid", 32'(resp_valid), 32'd1);
            chk("err_resp_err", 32'(resp_err), 32'd1);
            chk("err_no_mem", 32'({dmem_read, dmem_write}), 32'd0);
        end else begin
            for (int i = 1; i <= delay; i++) begin
                chk("acc_read", 32'(dmem_read), 32'(rd));
                chk("acc_write", 32'(dmem_write), 32'(wr));
                chk("acc_addr", dmem_address, addr - 32'(off));
                chk("acc_wmask", 32'(dmem_wmask), wr ? 32'(model_mask(f3, off)) : 32'd0);
                if (wr) chk("acc_wdata", dmem_wdata, model_wdata(f3, off, wd));
                chk("acc_no_resp", 32'(resp_valid), 32'd0);
                if (i == delay) begin
                    dmem_resp = 1'b1;
                    dmem_rdata = word;
                end
                tick();
                dmem_resp = 1'b0;
                dmem_rdata = $urandom;
            end
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_err", 32'(resp_err), 32'd0);
            chk("resp_rdata", resp_rdata, wr ? 32'd0 : model_load(f3, off, word));
            chk("resp_no_mem", 32'({dmem_read, dmem_write}), 32'd0);
        end
        tick();
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("resp_rdata_clr", resp_rdata, 32'd0);
        chk("stall_clr", 32'(stall), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_outs", 32'({resp_valid, resp_err, stall, dmem_read, dmem_write, dmem_wmask}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        do_req(0, 1, 2, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        do_req(0, 1, 0, 32'h103, 32'h000000A5, 32'h0, 1);
        do_req(1, 0, 0, 32'h202, 32'h0, 32'h12F45678, 1);
        do_req(1, 0, 4, 32'h202, 32'h0, 32'h12F45678, 1);
        do_req(1, 0, 1, 32'h301, 32'h0, 32'h0, 1);
        do_req(0, 1, 2, 32'h302, 32'h0, 32'h0, 1);
        do_req(1, 0, 3, 32'h300, 32'h0, 32'h0, 1);
        do_req(1, 1, 2, 32'h400, 32'h0, 32'h0, 1);

        // Neither read nor write: must not be accepted.
        req_valid = 1'b1;
        tick();
        tick();
        chk("noop_ready", 32'(req_ready), 32'd1);
        chk("noop_stall", 32'({stall, resp_valid}), 32'd0);
        req_valid = 1'b0;

        for (int n = 0; n < 250; n++) begin
            bit rd, wr;
            int f3;
            logic [31:0] a;
            if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
            else begin wr = 1'($urandom_range(0, 1)); rd = !wr; end
            f3 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7))
                 : (wr ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 5)));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3 == 2) a = a & 32'hFFFFFFFC;
                else if (f3 == 1 || f3 == 5) a = a & 32'hFFFFFFFE;
            end
            do_req(rd, wr, f3, a, $urandom, $urandom, int'($urandom_range(1, 4)));
        end

        // Reset while a load is in ACCESS; a late dmem_resp must be ignored.
        req_valid = 1'b1; req_read = 1'b1; req_funct3 = 3'd2; req_addr = 32'h500;
        tick();
        req_valid = 1'b0; req_read = 1'b0;
        tick();
        chk("pre_rst_read", 32'(dmem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({req_ready, resp_valid, resp_err, stall, dmem_read, dmem_write, dmem_wmask}), 32'd0);
        chk("async_rst_addr", dmem_address, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        dmem_resp = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_resp = 1'b0;
        chk("late_resp_ignored", 32'(resp_valid), 32'd0);
        chk("idle_after_rst", 32'({req_ready, stall}), 32'b10);
        tick();
        chk("late_resp_ignored2", 32'(resp_valid), 32'd0);
        do_req(1, 0, 5, 32'h602, 32'h0, 32'h8001ABCD, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
